ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
- Parametrised, elastic EX/MEM pipeline stage register: the next-generation replacement for the fixed EX/MEM latch.
- Carries PC+4, ALU result, store data, control bundle and destination register from the EX stage to the MEM stage.
- Adds a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and a configurable bubble (NOP) control encoding, so hazard and stall logic can hold or kill the stage without external muxing.

Parameters:
- DATA_W, 32, width of the pc_4, alu and sw data fields.
- CTRL_W, 8, width of the control bundle.
- REG_W, 5, width of the destination register index.
- CTRL_NOP, 1, control value driven for a bubble, after reset and after flush; must fit in CTRL_W.
- SKID, 1, selects buffering: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries; highest priority after reset.
- in_valid  input  1  EX stage presents a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- pc_4_in  input  DATA_W  PC+4.
- alu_in  input  DATA_W  ALU result.
- sw_in  input  DATA_W  store data.
- control_in  input  CTRL_W  control bundle.
- regdst_in  input  REG_W  destination register.
- out_valid  output  1  head entry valid toward MEM.
- out_ready  input  1  MEM stage consumes the head entry.
- pc_4_out  output  DATA_W  head entry PC+4.
- alu_out  output  DATA_W  head entry ALU result.
- sw_out  output  DATA_W  head entry store data.
- control_out  output  CTRL_W  head entry control, or CTRL_NOP when empty.
- regdst_out  output  REG_W  head entry destination register.
- occupancy  output  2  number of held entries (0..2).

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low. While reset=0:
  - all data outputs = 0; control_out = CTRL_NOP; out_valid = 0; occupancy = 0.
  - in_ready = 1 when SKID=1. When SKID=0, in_ready follows its combinational equation (equal to 1 while empty).
  - Reset asserted mid-transfer discards all entries immediately; no partial update survives.
- Handshake:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
  - in_valid is ignored when in_ready=0. The stage never drops or duplicates an accepted entry.
  - Ordering is strictly FIFO.
- Latency: an entry accepted at edge N is on the outputs with out_valid=1 after edge N (one cycle), provided the stage was empty or issuing.
- Output registers (head) and a skid register (SKID=1 only). All outputs come straight from registers; there is no combinational input-to-output path.
- FSM (SKID=1): states EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE (head <= input).
  - ONE:
    - accept & issue -> ONE (head <= input).
    - accept & !issue -> TWO (skid <= input).
    - !accept & issue -> EMPTY.
    - otherwise hold.
  - TWO: in_ready=0.
    - issue -> ONE (head <= skid).
    - otherwise hold. All outputs stay stable while out_valid=1 and out_ready=0.
  - in_ready = (state != TWO), registered.
  - occupancy: EMPTY=0, ONE=1, TWO=2.
- SKID=0:
  - States EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions as above, without TWO.
- Bubble: on any transition into EMPTY, control_out <= CTRL_NOP. Data fields retain their last values and are don't-care while out_valid=0.
- Flush = 1 at a rising edge (reset deasserted):
  - next state EMPTY; out_valid=0; control_out=CTRL_NOP.
  - in_ready=1 when SKID=1. When SKID=0, in_ready follows its combinational equation (equal to 1 while empty).
  - A simultaneous accept is discarded. A simultaneous issue still counts as consumed by MEM.
- Simultaneous accept and issue in ONE sustains full throughput: one entry per cycle, no bubble.
- Widths: all fields are passed through unmodified; no arithmetic.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and random inputs -> out_valid=0, control_out=1, all data outputs 0, occupancy=0. After release, first accept of alu_in=32'h0000_1234 -> alu_out=32'h0000_1234 with out_valid=1 one cycle later.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with alu_in=0..9 -> alu_out=0..9 on consecutive cycles, one cycle delayed, occupancy constant at 1, in_ready constantly 1.
- Backpressure: out_ready=0 while presenting A=32'hA, then B=32'hB -> occupancy 1 then 2; in_ready=0 from the cycle after B is accepted; alu_out holds 32'hA. Raise out_ready -> 32'hA issues, then 32'hB, then control_out=CTRL_NOP with out_valid=0.
- Flush in TWO: with occupancy=2 and in_valid=1 carrying C, assert flush for one cycle -> next cycle occupancy=0, out_valid=0, control_out=1, in_ready=1; C never appears on the outputs.
- Mid-operation reset: at occupancy=2, pulse reset low between clock edges -> outputs go to reset values immediately, before the next edge; the outputs then remain at reset values and no old entries ever reappear.
- SKID=0, CTRL_NOP=8'h00: with out_ready=0 and occupancy=1 -> in_ready=0 combinationally. Raise out_ready with in_valid=1 -> in_ready=1 in the same cycle and the head is replaced next edge. Flush -> control_out=8'h00.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: elastic EX/MEM register with optional 2-entry skid buffer, flush and bubble control
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int REG_W = 5,
  parameter logic [CTRL_W-1:0] CTRL_NOP = 1,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_4_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] sw_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [REG_W-1:0]  regdst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_4_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] sw_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  regdst_out,
  output logic [1:0]        occupancy
);
  localparam int W = 3*DATA_W + CTRL_W + REG_W;
  localparam logic [W-1:0] RST = {{3*DATA_W{1'b0}}, CTRL_NOP, {REG_W{1'b0}}};
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_n;
  logic [W-1:0] head, skid, din;
  logic rdy, acc, iss, ld_in, ld_skid, ld_head_skid;
  assign din = {pc_4_in, alu_in, sw_in, control_in, regdst_in};
  assign {pc_4_out, alu_out, sw_out, control_out, regdst_out} = head;
  assign out_valid = state != EMPTY;
  assign occupancy = state;
  assign in_ready = (SKID != 0) ? rdy : (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign iss = out_valid && out_ready;
  always_comb begin
    state_n = state;
    ld_in = 1'b0;
    ld_skid = 1'b0;
    ld_head_skid = 1'b0;
    case (state)
      EMPTY: if (acc) begin state_n = ONE; ld_in = 1'b1; end
      ONE:
        if (acc && iss) ld_in = 1'b1;
        else if (acc) begin state_n = TWO; ld_skid = 1'b1; end
        else if (iss) state_n = EMPTY;
      TWO: if (iss) begin state_n = ONE; ld_head_skid = 1'b1; end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
      ld_in = 1'b0;
      ld_skid = 1'b0;
      ld_head_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      rdy <= 1'b1;
      head <= RST;
      skid <= '0;
    end else begin
      state <= state_n;
      rdy <= state_n != TWO;
      if (ld_in) head <= din;
      else if (ld_head_skid) head <= skid;
      if (state_n == EMPTY) head[REG_W +: CTRL_W] <= CTRL_NOP;
      if (ld_skid) skid <= din;
    end
  end
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: directed checks of the skid and single-entry configurations
module tb_ex_mem_pipe_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_pc_in = 0, a_alu_in = 0, a_sw_in = 0, a_pc_out, a_alu_out, a_sw_out;
  logic [7:0] a_ctrl_in = 0, a_ctrl_out;
  logic [4:0] a_reg_in = 0, a_reg_out;
  logic [1:0] a_occ;
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_pc_in = 0, b_alu_in = 0, b_sw_in = 0, b_pc_out, b_alu_out, b_sw_out;
  logic [7:0] b_ctrl_in = 0, b_ctrl_out;
  logic [4:0] b_reg_in = 0, b_reg_out;
  logic [1:0] b_occ;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  ex_mem_pipe_stage #(.CTRL_NOP(8'h01), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pc_4_in(a_pc_in), .alu_in(a_alu_in), .sw_in(a_sw_in), .control_in(a_ctrl_in), .regdst_in(a_reg_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .pc_4_out(a_pc_out), .alu_out(a_alu_out),
    .sw_out(a_sw_out), .control_out(a_ctrl_out), .regdst_out(a_reg_out), .occupancy(a_occ));
  ex_mem_pipe_stage #(.CTRL_NOP(8'h00), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pc_4_in(b_pc_in), .alu_in(b_alu_in), .sw_in(b_sw_in), .control_in(b_ctrl_in), .regdst_in(b_reg_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .pc_4_out(b_pc_out), .alu_out(b_alu_out),
    .sw_out(b_sw_out), .control_out(b_ctrl_out), .regdst_out(b_reg_out), .occupancy(b_occ));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a_reset(input string tag);
    chk({tag, "_valid"}, a_out_valid, 0);
    chk({tag, "_occ"}, a_occ, 0);
    chk({tag, "_ctrl"}, a_ctrl_out, 8'h01);
    chk({tag, "_alu"}, a_alu_out, 0);
    chk({tag, "_pc"}, a_pc_out, 0);
    chk({tag, "_sw"}, a_sw_out, 0);
    chk({tag, "_reg"}, a_reg_out, 0);
    chk({tag, "_rdy"}, a_in_ready, 1);
  endtask
  initial begin
    a_in_valid = 1;
    a_pc_in = $urandom; a_alu_in = $urandom; a_sw_in = $urandom;
    a_ctrl_in = 8'($urandom); a_reg_in = 5'($urandom);
    #12;
    chk_a_reset("rst");
    chk("rst_b_ctrl", b_ctrl_out, 8'h00);
    chk("rst_b_rdy", b_in_ready, 1);
    chk("rst_b_occ", b_occ, 0);
    reset = 1;
    a_pc_in = 32'h100; a_alu_in = 32'h0000_1234; a_sw_in = 32'hDEAD;
    a_ctrl_in = 8'h3C; a_reg_in = 5'd7; a_out_ready = 1;
    tick;
    chk("first_alu", a_alu_out, 32'h0000_1234);
    chk("first_valid", a_out_valid, 1);
    chk("first_pc", a_pc_out, 32'h100);
    chk("first_sw", a_sw_out, 32'hDEAD);
    chk("first_ctrl", a_ctrl_out, 8'h3C);
    chk("first_reg", a_reg_out, 7);
    chk("first_occ", a_occ, 1);
    for (int i = 0; i < 10; i++) begin
      a_alu_in = i;
      tick;
      chk("stream_alu", a_alu_out, i);
      chk("stream_occ", a_occ, 1);
      chk("stream_rdy", a_in_ready, 1);
    end
    a_in_valid = 0;
    tick;
    chk("drain_valid", a_out_valid, 0);
    chk("drain_ctrl", a_ctrl_out, 8'h01);
    a_in_valid = 1; a_out_ready = 0; a_alu_in = 32'hA;
    tick;
    chk("bp_a_occ", a_occ, 1);
    chk("bp_a_rdy", a_in_ready, 1);
    a_alu_in = 32'hB;
    tick;
    chk("bp_b_occ", a_occ, 2);
    chk("bp_b_rdy", a_in_ready, 0);
    chk("bp_b_alu", a_alu_out, 32'hA);
    a_alu_in = 32'hC;
    tick;
    chk("bp_hold_occ", a_occ, 2);
    chk("bp_hold_alu", a_alu_out, 32'hA);
    a_in_valid = 0; a_out_ready = 1;
    tick;
    chk("bp_pop_alu", a_alu_out, 32'hB);
    chk("bp_pop_occ", a_occ, 1);
    chk("bp_pop_rdy", a_in_ready, 1);
    tick;
    chk("bp_empty_valid", a_out_valid, 0);
    chk("bp_empty_ctrl", a_ctrl_out, 8'h01);
    a_in_valid = 1; a_out_ready = 0; a_alu_in = 32'hA;
    tick;
    a_alu_in = 32'hB;
    tick;
    chk("fl_pre_occ", a_occ, 2);
    a_alu_in = 32'hC; a_flush = 1;
    tick;
    chk("fl_occ", a_occ, 0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ctrl", a_ctrl_out, 8'h01);
    chk("fl_rdy", a_in_ready, 1);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    tick;
    chk("fl_after_valid", a_out_valid, 0);
    chk("fl_after_occ", a_occ, 0);
    a_in_valid = 1; a_out_ready = 0; a_alu_in = 32'h55;
    tick;
    a_alu_in = 32'h66;
    tick;
    chk("mr_pre_occ", a_occ, 2);
    a_in_valid = 0;
    #3 reset = 0;
    #1;
    chk_a_reset("mr");
    #1 reset = 1;
    a_out_ready = 1;
    tick;
    chk("mr_after_valid", a_out_valid, 0);
    chk("mr_after_alu", a_alu_out, 0);
    tick;
    chk("mr_after2_valid", a_out_valid, 0);
    chk("mr_after2_occ", a_occ, 0);
    b_in_valid = 1; b_alu_in = 32'h11; b_ctrl_in = 8'h77;
    tick;
    chk("b_one_occ", b_occ, 1);
    chk("b_one_alu", b_alu_out, 32'h11);
    chk("b_one_ctrl", b_ctrl_out, 8'h77);
    chk("b_rdy_low", b_in_ready, 0);
    b_alu_in = 32'h22;
    tick;
    chk("b_hold_alu", b_alu_out, 32'h11);
    b_out_ready = 1;
    #1;
    chk("b_rdy_comb", b_in_ready, 1);
    tick;
    chk("b_repl_alu", b_alu_out, 32'h22);
    chk("b_repl_occ", b_occ, 1);
    b_in_valid = 0; b_out_ready = 0; b_flush = 1;
    tick;
    chk("b_fl_ctrl", b_ctrl_out, 8'h00);
    chk("b_fl_valid", b_out_valid, 0);
    chk("b_fl_rdy", b_in_ready, 1);
    b_flush = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
